// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback port identifiers.
// Imported by the writeback arbiter and by the register file itself.
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef enum logic {
        WB_CORE = 1'b0,
        WB_LONG = 1'b1
    } wb_port_e;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        return NREGS'(1) << r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant remembers the most recent winner
// so the other port wins the next contention.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       xfer,
    output logic [1:0] grant
);

    wb_port_e last_grant;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == WB_LONG) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset to WB_LONG so the core port wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= WB_LONG;
        end else if (xfer) begin
            last_grant <= grant[1] ? WB_LONG : WB_CORE;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the core writeback and a
// long-latency unit, and tracks registers the long-latency unit still owes.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN   = rf_pkg::XLEN,
    parameter int REG_AW = rf_pkg::REG_AW,
    parameter int NREGS  = rf_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb0_valid,
    input  logic [REG_AW-1:0] wb0_rd,
    input  logic [XLEN-1:0]   wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [REG_AW-1:0] wb1_rd,
    input  logic [XLEN-1:0]   wb1_data,
    output logic              wb1_ready,
    input  logic              claim_valid,
    input  logic [REG_AW-1:0] claim_rd,
    output logic [NREGS-1:0]  pending_mask,
    output logic              claim_err,
    output logic              regWrite,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   writeData
);

    logic [1:0]        grant;
    logic              xfer0, xfer1, xfer;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;
    logic              we_p1;
    logic [NREGS-1:0]  set_vec, clr_vec;
    logic              claim_set;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({wb1_valid, wb0_valid}),
        .xfer  (xfer),
        .grant (grant)
    );

    assign wb0_ready = grant[0];
    assign wb1_ready = grant[1];
    assign xfer0     = wb0_valid && wb0_ready;
    assign xfer1     = wb1_valid && wb1_ready;
    assign xfer      = xfer0 || xfer1;

    always_comb begin
        win_rd   = wb0_rd;
        win_data = wb0_data;
        if (xfer1) begin
            win_rd   = wb1_rd;
            win_data = wb1_data;
        end
    end

    // ---- p0 -> p1: winning write registered onto the register-file port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            we_p1     <= 1'b0;
            rd        <= '0;
            writeData <= '0;
        end else if (xfer) begin
            we_p1     <= (win_rd != '0);
            rd        <= win_rd;
            writeData <= win_data;
        end else begin
            we_p1     <= 1'b0;
        end
    end

    // A reset in the write cycle drops the registered write before it commits.
    assign regWrite = we_p1 && !rst;

    assign claim_set = claim_valid && (claim_rd != '0);
    assign set_vec   = claim_set ? reg_onehot(claim_rd) : '0;
    assign clr_vec   = xfer1 ? reg_onehot(wb1_rd) : '0;

    // Set is applied after clear: a same-cycle claim is younger than the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_mask <= '0;
            claim_err    <= 1'b0;
        end else begin
            pending_mask <= (pending_mask & ~clr_vec) | set_vec;
            claim_err    <= claim_set && |(pending_mask & set_vec) && !(|(clr_vec & set_vec));
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb0_valid = 1'b0, wb1_valid = 1'b0, claim_valid = 1'b0;
    logic [4:0]  wb0_rd = '0, wb1_rd = '0, claim_rd = '0;
    logic [31:0] wb0_data = '0, wb1_data = '0;
    logic        wb0_ready, wb1_ready, claim_err, regWrite;
    logic [31:0] pending_mask;
    logic [4:0]  rd;
    logic [31:0] writeData;

    int checks = 0;
    int failures = 0;

    logic [31:0] tb_rf [32] = '{default: 32'd0};

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .claim_valid(claim_valid), .claim_rd(claim_rd),
        .pending_mask(pending_mask), .claim_err(claim_err),
        .regWrite(regWrite), .rd(rd), .writeData(writeData)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT's write port.
    always @(posedge clk) if (regWrite) tb_rf[rd] <= writeData;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected state after the most recent edge.
    bit          model_on = 0;
    int          m_last = 1;
    bit          m_we = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_mask = '0;
    bit          m_err = 0;

    always @(negedge clk) begin
        bit e0, e1, claimed;
        e0 = 0; e1 = 0;
        if (!rst) begin
            if (wb0_valid && wb1_valid) begin
                e0 = (m_last == 1);
                e1 = (m_last == 0);
            end else begin
                e0 = wb0_valid;
                e1 = wb1_valid;
            end
        end
        if (model_on) begin
            chk("m_wb0_ready", wb0_ready, e0);
            chk("m_wb1_ready", wb1_ready, e1);
            chk("m_regWrite", regWrite, m_we && !rst);
            if (m_we && !rst) begin
                chk("m_rd", rd, m_rd);
                chk("m_writeData", writeData, m_data);
            end
            chk("m_pending_mask", pending_mask, m_mask);
            chk("m_claim_err", claim_err, m_err);
        end
        if (rst) begin
            model_on = 1;
            m_last = 1; m_we = 0; m_rd = '0; m_data = '0; m_mask = '0; m_err = 0;
        end else if (model_on) begin
            m_we = 0;
            if (e0 || e1) begin
                m_rd   = e0 ? wb0_rd : wb1_rd;
                m_data = e0 ? wb0_data : wb1_data;
                m_we   = (m_rd != 0);
                m_last = e0 ? 0 : 1;
            end
            claimed = claim_valid && (claim_rd != 0);
            m_err = claimed && m_mask[claim_rd] && !(e1 && wb1_rd == claim_rd);
            if (e1) m_mask[wb1_rd] = 1'b0;
            if (claimed) m_mask[claim_rd] = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gseq [4];
        bit f0, f1;

        // Reset and single write
        wb0_valid = 1; wb0_rd = 5'd8; wb0_data = 32'd123;
        step(); step();
        #1;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_rd", rd, 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_mask", pending_mask, 0);
        chk("rst_claim_err", claim_err, 0);
        chk("rst_ready0", wb0_ready, 0);
        step();
        rst = 0;
        #1 chk("w8_ready", wb0_ready, 1);
        step();
        wb0_valid = 0;
        #1;
        chk("w8_regWrite", regWrite, 1);
        chk("w8_rd", rd, 8);
        chk("w8_data", writeData, 123);
        step();
        #1;
        chk("w8_regWrite_off", regWrite, 0);
        chk("w8_readback", tb_rf[8], 123);

        // Contention round-robin after a fresh reset
        rst = 1;
        step();
        rst = 0;
        wb0_valid = 1; wb0_rd = 5'd1; wb0_data = 32'hA;
        wb1_valid = 1; wb1_rd = 5'd2; wb1_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            #1 gseq[i] = wb0_ready ? 0 : (wb1_ready ? 1 : 2);
            step();
        end
        wb0_valid = 0; wb1_valid = 0;
        chk("rr_g0", gseq[0], 0);
        chk("rr_g1", gseq[1], 1);
        chk("rr_g2", gseq[2], 0);
        chk("rr_g3", gseq[3], 1);
        step();
        chk("rr_x1", tb_rf[1], 32'hA);
        chk("rr_x2", tb_rf[2], 32'hB);

        // x0 write
        wb1_valid = 1; wb1_rd = 5'd0; wb1_data = 32'd234234;
        #1 chk("x0_ready", wb1_ready, 1);
        step();
        wb1_valid = 0;
        #1 chk("x0_regWrite", regWrite, 0);
        step();
        chk("x0_read", tb_rf[0], 0);

        // Scoreboard lifecycle on x25
        claim_valid = 1; claim_rd = 5'd25;
        step();
        claim_valid = 0;
        #1 chk("sb_set25", pending_mask[25], 1);
        wb1_valid = 1; wb1_rd = 5'd25; wb1_data = 32'd234234;
        #1 chk("sb_ready25", wb1_ready, 1);
        step();
        wb1_valid = 0;
        #1;
        chk("sb_clr25", pending_mask[25], 0);
        chk("sb_we25", regWrite, 1);
        chk("sb_rd25", rd, 25);

        // Simultaneous set/clear, then a conflicting claim
        claim_valid = 1; claim_rd = 5'd5;
        step();
        wb1_valid = 1; wb1_rd = 5'd5; wb1_data = 32'd9;
        #1 chk("sc_ready5", wb1_ready, 1);
        step();
        claim_valid = 0; wb1_valid = 0;
        #1;
        chk("sc_mask5", pending_mask[5], 1);
        chk("sc_err0", claim_err, 0);
        claim_valid = 1;
        step();
        claim_valid = 0;
        #1 chk("cf_err1", claim_err, 1);
        step();
        #1;
        chk("cf_err_pulse", claim_err, 0);
        chk("cf_mask5", pending_mask[5], 1);

        // Reset mid-operation
        wb0_valid = 1; wb0_rd = 5'd3; wb0_data = 32'd77;
        #1 chk("rm_ready", wb0_ready, 1);
        step();
        wb0_valid = 0; rst = 1;
        #1 chk("rm_we_in_rst", regWrite, 0);
        step();
        rst = 0;
        #1;
        chk("rm_regWrite", regWrite, 0);
        chk("rm_mask", pending_mask, 0);
        chk("rm_x3", tb_rf[3], 0);

        // Randomized traffic obeying the hold-until-ready rule
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            f0 = wb0_valid && wb0_ready;
            f1 = wb1_valid && wb1_ready;
            step();
            rst = ($urandom_range(0, 199) == 0);
            if (f0 || !wb0_valid) begin
                wb0_valid = ($urandom_range(0, 3) != 0);
                wb0_rd    = 5'($urandom_range(0, 31));
                wb0_data  = $urandom;
            end
            if (f1 || !wb1_valid) begin
                wb1_valid = ($urandom_range(0, 2) == 0);
                wb1_rd    = 5'($urandom_range(0, 7));
                wb1_data  = $urandom;
            end
            claim_valid = ($urandom_range(0, 2) == 0);
            claim_rd    = 5'($urandom_range(0, 7));
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
